uart_tx_feeder: RTL and testbench



---
 rtl/uart_tx_feeder_if.sv | 38 +++
 rtl/uart_tx_feeder.sv | 141 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if
// Bundles the host-side FIFO signals and the core-side transmit handshake
// of uart_tx_feeder.
//   Host side : wr_data, wr_en, flush, clr_flags  -> feeder
//               full, empty, level, overflow, lost <- feeder
//   Core side : tx_data, tx_req                    -> UART core
//               tx_busy                            <- UART core
// Modports:
//   slave  - the feeder itself
//   master - the surrounding host logic and UART core (or a testbench)
// -----------------------------------------------------------------------------
interface uart_tx_feeder_if #(
   parameter int AW = 3
);
   logic [7:0]  wr_data;
   logic        wr_en;
   logic        flush;
   logic        clr_flags;
   logic        full;
   logic        empty;
   logic [AW:0] level;
   logic        overflow;
   logic        lost;
   logic [7:0]  tx_data;
   logic        tx_req;
   logic        tx_busy;

   modport slave (
      input  wr_data, wr_en, flush, clr_flags, tx_busy,
      output full, empty, level, overflow, lost, tx_data, tx_req
   );

   modport master (
      output wr_data, wr_en, flush, clr_flags, tx_busy,
      input  full, empty, level, overflow, lost, tx_data, tx_req
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Transmit-side byte FIFO placed in front of the UART core's transmitter.
// Host writes are buffered in a DEPTH-entry FIFO; a three-state drain FSM
// hands one byte at a time to the core with a single-cycle tx_req pulse and
// follows the core's tx_busy to know when the frame is done.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - uart_tx_feeder_if.slave (host FIFO signals + core handshake)
// Parameters:
//   DEPTH - FIFO entries, power of two, >= 2
//   AW    - log2(DEPTH)
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_feeder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   state_t      state, state_nxt;
   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] level_w;
   logic [1:0]  to_cnt, to_cnt_nxt;
   logic        tx_req_nxt;
   logic        full_w, empty_w;
   logic        push, pop;
   logic        ovf_set, lost_set;

   // Pointers carry one extra wrap bit, so the difference is the fill level.
   assign level_w = wr_ptr - rd_ptr;
   assign full_w  = (level_w == FULL_LEVEL);
   assign empty_w = (level_w == '0);

   // full is judged on the pre-edge level, so a same-cycle pop does not
   // rescue a write made at full.
   assign push    = bus.wr_en && !full_w && !bus.flush;
   assign ovf_set = bus.wr_en &&  full_w && !bus.flush;

   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.level    = level_w;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_nxt  = state;
      to_cnt_nxt = to_cnt;
      tx_req_nxt = 1'b0;
      pop        = 1'b0;
      lost_set   = 1'b0;
      case (state)
         IDLE: begin
            if (!empty_w && !bus.tx_busy && !bus.flush) begin
               pop        = 1'b1;
               tx_req_nxt = 1'b1;
               to_cnt_nxt = '0;
               state_nxt  = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (to_cnt == 2'd3) begin
               // Core never answered: the byte is counted as consumed.
               lost_set  = 1'b1;
               state_nxt = IDLE;
            end else begin
               to_cnt_nxt = to_cnt + 2'd1;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         to_cnt     <= '0;
         bus.tx_req <= 1'b0;
      end else begin
         state      <= state_nxt;
         to_cnt     <= to_cnt_nxt;
         bus.tx_req <= tx_req_nxt;
      end
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         bus.tx_data <= '0;
      end else begin
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
         if (pop) bus.tx_data <= mem[rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
   end

   // Sticky flags: a set event in the same cycle beats clr_flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.overflow <= 1'b0;
         bus.lost     <= 1'b0;
      end else begin
         if (ovf_set)            bus.overflow <= 1'b1;
         else if (bus.clr_flags) bus.overflow <= 1'b0;
         if (lost_set)           bus.lost     <= 1'b1;
         else if (bus.clr_flags) bus.lost     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Scoreboard bench for uart_tx_feeder. The stimulus process keeps a byte
// queue modelling FIFO contents plus expected sticky flags; a monitor on the
// falling edge pops the queue on every tx_req and checks data, level and
// flags. A small UART core model answers requests with tx_busy.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   uart_tx_feeder_if #(.AW(AW)) bus ();

   uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [7:0] fifo_q [$];
   bit         ov_exp    = 1'b0;
   bit         lost_exp  = 1'b0;
   int         lost_due  = -1;
   int         cyc       = 0;
   int         nreq      = 0;

   // core model controls
   bit         core_mute = 1'b0;
   bit         core_hold = 1'b0;
   int         frame_len = 2;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // One clock of stimulus, followed by the reference-model update for that edge.
   task automatic step(input bit we, input logic [7:0] d, input bit fl, input bit clr);
      bit was_full;
      bus.wr_en     = we;
      bus.wr_data   = d;
      bus.flush     = fl;
      bus.clr_flags = clr;
      @(posedge clk);
      #1;
      cyc++;
      // Entries popped at this edge leave the queue on the next falling edge,
      // so the queue size here is the level before the edge.
      was_full = (fifo_q.size() == DEPTH);
      if (fl)                 fifo_q.delete();
      else if (we && !was_full) fifo_q.push_back(d);
      if (we && was_full && !fl) ov_exp = 1'b1;
      else if (clr)              ov_exp = 1'b0;
      if (lost_due == cyc) begin
         lost_exp = 1'b1;
         lost_due = -1;
      end else if (clr) begin
         lost_exp = 1'b0;
      end
      // An unanswered request must end in lost four cycles after it rose.
      if (bus.tx_req && core_mute) lost_due = cyc + 4;
   endtask

   // UART core model: answers a request one cycle later with tx_busy held for
   // frame_len cycles; core_hold forces busy, core_mute ignores requests.
   initial begin : core_model
      int cstate;
      int ccnt;
      cstate = 0;
      ccnt   = 0;
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.tx_busy = 1'b0;
            cstate      = 0;
         end else if (core_hold) begin
            bus.tx_busy = 1'b1;
            cstate      = 0;
         end else begin
            case (cstate)
               0: begin
                  bus.tx_busy = 1'b0;
                  if (bus.tx_req && !core_mute) begin
                     cstate = 1;
                     ccnt   = 1;
                  end
               end
               1: begin
                  ccnt--;
                  if (ccnt == 0) begin
                     bus.tx_busy = 1'b1;
                     cstate      = 2;
                     ccnt        = frame_len;
                  end
               end
               default: begin
                  ccnt--;
                  if (ccnt == 0) begin
                     bus.tx_busy = 1'b0;
                     cstate      = 0;
                  end
               end
            endcase
         end
      end
   end

   // Monitor: every tx_req consumes the oldest modelled byte.
   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (bus.tx_req) begin
            nreq++;
            if (fifo_q.size() == 0) begin
               check("unexpected_tx_req", bus.tx_req, 1'b0);
            end else begin
               e = fifo_q.pop_front();
               check("tx_data", bus.tx_data, e);
            end
         end
         check("level", bus.level, fifo_q.size());
         check("full", bus.full, fifo_q.size() == DEPTH);
         check("empty", bus.empty, fifo_q.size() == 0);
         check("overflow", bus.overflow, ov_exp);
         check("lost", bus.lost, lost_exp);
      end
   end

   initial begin : stim
      int  n0;
      bit  found;
      bit  c;
      bit  we, fl, clr;

      bus.wr_en     = 1'b0;
      bus.wr_data   = '0;
      bus.flush     = 1'b0;
      bus.clr_flags = 1'b0;

      // ---- reset state
      #12;
      check("rst_level", bus.level, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_tx_req", bus.tx_req, 0);
      check("rst_tx_data", bus.tx_data, 8'h00);
      check("rst_overflow", bus.overflow, 0);
      check("rst_lost", bus.lost, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 8'h00, 0, 0);

      // ---- single byte, idle core
      n0 = nreq;
      step(1, 8'hA5, 0, 0);
      check("t1_level_after_write", bus.level, 1);
      check("t1_req_not_yet", bus.tx_req, 0);
      step(0, 8'h00, 0, 0);
      check("t1_req_pulse", bus.tx_req, 1);
      check("t1_tx_data", bus.tx_data, 8'hA5);
      check("t1_level_after_pop", bus.level, 0);
      step(0, 8'h00, 0, 0);
      check("t1_req_one_cycle", bus.tx_req, 0);
      repeat (20) step(0, 8'h00, 0, 0);
      check("t1_req_count", nreq - n0, 1);
      // FSM is back in IDLE: the next write is requested with the same latency
      step(1, 8'h5A, 0, 0);
      step(0, 8'h00, 0, 0);
      check("t1_idle_again", bus.tx_req, 1);
      repeat (10) step(0, 8'h00, 0, 0);

      // ---- fill to full with busy held, ninth write dropped
      n0 = nreq;
      core_hold = 1'b1;
      step(0, 8'h00, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         step(1, 8'(i), 0, 0);
         if (i == 8) begin
            check("t2_full", bus.full, 1);
            check("t2_level8", bus.level, 8);
            check("t2_no_ovf_yet", bus.overflow, 0);
         end
      end
      check("t2_overflow", bus.overflow, 1);
      check("t2_level_still8", bus.level, 8);
      core_hold = 1'b0;
      repeat (80) step(0, 8'h00, 0, 0);
      check("t2_req_count", nreq - n0, 8);
      step(0, 8'h00, 0, 1);
      check("t2_ovf_cleared", bus.overflow, 0);

      // ---- simultaneous write and pop at level 3
      core_hold = 1'b1;
      step(0, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 0, 0);
      check("t3_level3", bus.level, 3);
      core_hold = 1'b0;
      step(1, 8'h33, 0, 0);
      check("t3_level_kept", bus.level, 3);
      check("t3_req", bus.tx_req, 1);
      repeat (40) step(0, 8'h00, 0, 0);

      // ---- write at full with a same-cycle pop is still dropped
      core_hold = 1'b1;
      step(0, 8'h00, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 8'h40 + 8'(i), 0, 0);
      core_hold = 1'b0;
      step(1, 8'hEE, 0, 0);
      check("t3_full_pop_req", bus.tx_req, 1);
      check("t3_full_pop_level", bus.level, 7);
      check("t3_full_pop_ovf", bus.overflow, 1);
      repeat (60) step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 1);

      // ---- core never answers: lost after four cycles, clr vs new timeout
      n0 = nreq;
      core_mute = 1'b1;
      step(1, 8'hC1, 0, 0);
      step(1, 8'hC2, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         step(0, 8'h00, 0, 0);
         if (lost_exp) found = 1'b1;
      end
      check("t4_first_timeout", found, 1);
      check("t4_lost_set", bus.lost, 1);
      step(0, 8'h00, 0, 1);
      check("t4_lost_cleared", bus.lost, 0);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         c = (lost_due == cyc + 1);
         step(0, 8'h00, 0, c);
         if (c) found = 1'b1;
      end
      check("t4_clr_on_timeout_seen", found, 1);
      check("t4_set_beats_clr", bus.lost, 1);
      step(0, 8'h00, 0, 1);
      core_mute = 1'b0;
      check("t4_req_count", nreq - n0, 2);
      repeat (4) step(0, 8'h00, 0, 0);

      // ---- flush with five bytes queued and a frame in flight
      n0 = nreq;
      frame_len = 30;
      for (int i = 0; i < 6; i++) step(1, 8'h60 + 8'(i), 0, 0);
      check("t5_level5", bus.level, 5);
      step(1, 8'h77, 1, 0);
      check("t5_level0", bus.level, 0);
      check("t5_no_ovf", bus.overflow, 0);
      repeat (50) step(0, 8'h00, 0, 0);
      check("t5_req_count", nreq - n0, 1);
      frame_len = 2;

      // ---- asynchronous reset in WAIT_DONE
      frame_len = 20;
      core_hold = 1'b1;
      step(0, 8'h00, 0, 0);
      for (int i = 1; i <= 9; i++) step(1, 8'h80 + 8'(i), 0, 0);
      core_hold = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(0, 8'h00, 0, 0);
         if (bus.tx_req) found = 1'b1;
      end
      check("t6_req_seen", found, 1);
      repeat (4) step(0, 8'h00, 0, 0);
      check("t6_pre_overflow", bus.overflow, 1);
      #2;
      rst_n = 1'b0;
      fifo_q.delete();
      ov_exp   = 1'b0;
      lost_exp = 1'b0;
      lost_due = -1;
      #1;
      check("t6_rst_tx_req", bus.tx_req, 0);
      check("t6_rst_tx_data", bus.tx_data, 8'h00);
      check("t6_rst_level", bus.level, 0);
      check("t6_rst_empty", bus.empty, 1);
      check("t6_rst_full", bus.full, 0);
      check("t6_rst_overflow", bus.overflow, 0);
      check("t6_rst_lost", bus.lost, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      frame_len = 2;
      repeat (3) step(0, 8'h00, 0, 0);

      // ---- randomized traffic
      for (int i = 0; i < 600; i++) begin
         we  = ($urandom_range(0, 99) < 45);
         fl  = ($urandom_range(0, 99) < 3);
         clr = ($urandom_range(0, 99) < 5);
         frame_len = $urandom_range(1, 4);
         step(we, 8'($urandom), fl, clr);
      end
      repeat (120) step(0, 8'h00, 0, 0);
      check("rand_drained", fifo_q.size(), 0);
      check("rand_empty", bus.empty, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
